// File: rtl/rows_round_ctrl_if.sv
// rtl/rows_round_ctrl_if.sv - handshake bundle for the row-permutation sequencer (dec exists only with ROWS_DECRYPT_EN)
interface rows_round_ctrl_if #(
  parameter int ROUNDS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [127:0]          in_state;
  logic [2*ROUNDS-1:0]   in_key;
  logic                  out_valid;
  logic                  out_ready;
  logic [127:0]          out_state;
  logic                  busy;
  logic [5:0]            round_idx;
`ifdef ROWS_DECRYPT_EN
  logic                  dec;

  modport master (
    output in_valid, in_state, in_key, dec, out_ready,
    input  in_ready, out_valid, out_state, busy, round_idx
  );
  modport slave (
    input  in_valid, in_state, in_key, dec, out_ready,
    output in_ready, out_valid, out_state, busy, round_idx
  );
`else
  modport master (
    output in_valid, in_state, in_key, out_ready,
    input  in_ready, out_valid, out_state, busy, round_idx
  );
  modport slave (
    input  in_valid, in_state, in_key, out_ready,
    output in_ready, out_valid, out_state, busy, round_idx
  );
`endif
endinterface

// File: rtl/rows_round_ctrl.sv
// rtl/rows_round_ctrl.sv - multi-round 4-row byte-permutation sequencer (optional ROWS_DECRYPT_EN reverses key order)
module rows_round_ctrl #(
  parameter int ROUNDS = 8
) (
  input  logic               clk,
  input  logic               rst,
  rows_round_ctrl_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [5:0] LAST   = 6'(ROUNDS - 1);

  logic [1:0]          state;
  logic [5:0]          cnt;
  logic [127:0]        st_q;
  logic [2*ROUNDS-1:0] key_q;
  logic [5:0]          key_idx;
  logic [1:0]          sel;
  logic [127:0]        st_perm;

  function automatic logic [127:0] perm(input logic [127:0] s, input logic [1:0] k);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = s;
    case (k)
      2'b00:   perm = {c, b, a, d};
      2'b01:   perm = {a, d, c, b};
      2'b10:   perm = {b, a, d, c};
      default: perm = {d, c, b, a};
    endcase
  endfunction

`ifdef ROWS_DECRYPT_EN
  logic dec_q;

  always_ff @(posedge clk) begin
    if (rst)
      dec_q <= 1'b0;
    else if (state == S_IDLE && bus.in_valid)
      dec_q <= bus.dec;
  end

  // Self-inverse rounds: walking the key pairs backwards undoes an encryption.
  assign key_idx = dec_q ? (LAST - cnt) : cnt;
`else
  assign key_idx = cnt;
`endif

  assign sel     = key_q[2*key_idx +: 2];
  assign st_perm = perm(st_q, sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      st_q  <= '0;
      key_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            st_q  <= bus.in_state;
            key_q <= bus.in_key;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          st_q <= st_perm;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_ready is held low while reset is applied so nothing is offered during the reset cycle.
  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_RUN);
  assign bus.round_idx = (state == S_RUN) ? cnt : 6'd0;
  assign bus.out_state = st_q;
endmodule

// File: doc/rows_round_ctrl.md
# rows_round_ctrl

Multi-round sequencer for the 4-row byte-permutation stage of the cipher datapath. It accepts a 128-bit state and a round key over a valid/ready handshake. It then applies one key-selected row permutation per clock for `ROUNDS` cycles and presents the result on a second valid/ready handshake. It sits between the state loader and the downstream mixing stage, and it contains the permutation itself.

## Interface
Parameters:
- `ROUNDS`, default 8: rounds per block. Legal range is 1–64.

Ports:
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `in_valid` in 1: the source offers `in_state`/`in_key`.
- `in_ready` out 1: the block can accept. It is high only in IDLE.
- `in_state` in 128: row a = [127:96], b = [95:64], c = [63:32], d = [31:0]. Each row is 4 bytes.
- `in_key` in 2*ROUNDS: round i uses `in_key[2i+1:2i]` as sel = {s3,s4}.
- `out_valid` out 1: the result is valid. It is high only in DONE.
- `out_ready` in 1: the sink accepts the result.
- `out_state` out 128: the permuted state, with the same row layout as `in_state`.
- `busy` out 1: high in RUN.
- `round_idx` out 6: the index of the round applied on the next edge in RUN. It is 0 otherwise.
- `dec` in 1: present only with `ROWS_DECRYPT_EN`. It is sampled at accept.

## Operation
Row permutation, written as new rows (a,b,c,d) taken from old rows:
- sel=00 gives (c,b,a,d).
- sel=01 gives (a,d,c,b).
- sel=10 gives (b,a,d,c).
- sel=11 gives (d,c,b,a).
- Every mapping is its own inverse.

FSM states:
- IDLE:
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`: latch the state into `st_q` and the key into `key_q`, set cnt=0, go to RUN.
- RUN:
  - Each edge: `st_q` ← perm(`st_q`, sel(cnt)), then cnt++.
  - When cnt==ROUNDS-1, the edge applies the last round and goes to DONE.
  - `in_valid` is ignored.
- DONE:
  - `out_valid`=1 and `out_state`=`st_q`.
  - When `out_ready`: go to IDLE.
  - There is no IDLE bypass: a new accept happens no earlier than the cycle after the handoff.

Other rules:
- sel(cnt) = `key_q[2cnt+1:2cnt]`. The key register is not modified during RUN.
- `out_state` reads `st_q` in every state. It is only meaningful when `out_valid`=1.
- Reset values:
  - FSM = IDLE, cnt = 0, `st_q` = 0, `key_q` = 0.
  - `in_ready`=0 during the reset cycle and 1 on the first cycle after it.
  - `out_valid`=0, `busy`=0, `round_idx`=0, `out_state`=0.
- Reset mid-operation (RUN or DONE) discards the block with no output. `rst` has priority over every handshake.
- ROUNDS=1: exactly one RUN cycle.

## Timing
- The accept edge is t.
- RUN occupies cycles t+1 … t+ROUNDS.
- `out_valid` rises in cycle t+ROUNDS+1 and holds, with `out_state` stable, until `out_ready` is sampled high.
- Minimum period per block is ROUNDS+2 cycles: accept, ROUNDS run cycles, handoff.
- `in_ready` and `out_valid` are registered-state decodes. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `ROWS_DECRYPT_EN` defined:
  - Adds the `dec` port, latched at accept.
  - With `dec`=1, round i uses key pair ROUNDS-1-i. Because every permutation is self-inverse, this undoes an encryption made with the same key.
  - With `dec`=0, behaviour is identical to the undefined build.
- `ROWS_DECRYPT_EN` undefined:
  - No `dec` port.
  - Key pairs are always consumed in ascending order.

## Test plan
Common stimulus: a=0x00010203, b=0x10111213, c=0x20212223, d=0x30313233. ROUNDS=8 unless noted.

- **Identity key.** Key 0x0000 -> after 8 swaps of a/c, `out_state` equals the input. `out_valid` rises exactly 9 cycles after the accept edge.
- **Single reverse round.** Key 0x0003 -> `out_state` = 0x10111213_20212223_30313233_00010203. `busy` is high for 8 cycles. `round_idx` steps 0…7.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` and `out_state` are stable, `in_ready`=0, and a concurrent `in_valid` is not accepted. Then raise `out_ready` -> IDLE next cycle, with `in_ready`=1.
- **Reset mid-run.** Assert `rst` at round 4 -> next cycle: IDLE, `out_valid`=0, `in_ready`=1, `out_state`=0. The following block computes correctly.
- **ROUNDS=1.** Key 0x1 -> output (a,d,c,b) = 0x00010203_30313233_20212223_10111213. `out_valid` rises 2 cycles after accept.
- **Round trip (`ROWS_DECRYPT_EN`).** Encrypt with key 0xB4E1 -> result R. Decrypt R with `dec`=1 and key 0xB4E1 -> original input.
